// File: rtl/klp32_fetch_unit.sv
// Instruction fetch unit: credit-limited requests to an in-order instruction
// memory, a prefetch FIFO toward decode, and redirect flush with stale-response drop.
module klp32_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [XLEN-1:0]            inst_data,
  output logic [XLEN-1:0]            inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t [DEPTH-1:0] fifo_q;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      occ, outstanding, discard, outstanding_nxt;
  logic [XLEN-1:0]    fetch_pc, rsp_pc, redirect_tgt;
  logic               boot, req_fire, rsp_take, push, pop;

  assign redirect_tgt    = redirect_pc & ~XLEN'(3);
  // Credit counts buffered plus in-flight words so a returning response always has a slot.
  assign imem_req_valid  = !reset && !boot && !redirect_valid &&
                           (({1'b0, occ} + {1'b0, outstanding}) < DEPTH_C);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp_take        = !reset && imem_rsp_valid && (outstanding != '0);
  assign push            = rsp_take && (discard == '0) && !redirect_valid;
  assign inst_valid      = !reset && (occ != '0) && !redirect_valid;
  assign pop             = inst_valid && inst_ready;
  assign inst_data       = fifo_q[rd_ptr].inst;
  assign inst_pc         = fifo_q[rd_ptr].pc;
  assign fifo_count      = reset ? '0 : occ;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);

  always_ff @(posedge clk) begin
    if (reset) begin
      boot        <= 1'b1;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      boot        <= 1'b0;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        discard  <= outstanding_nxt;
        occ      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_take && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: rsp_pc, inst: imem_rsp_data};
  end

endmodule

// File: tb/tb_klp32_fetch_unit.sv
// Bench for klp32_fetch_unit: random memory/decode timing against a queue-based
// model of the architectural fetch stream, plus directed corner scenarios.
module tb_klp32_fetch_unit;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic [2:0]  fifo_count;

  logic        w_req_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_inst_data, w_inst_pc;
  logic [2:0]  w_fifo_count;

  klp32_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fifo_count(fifo_count)
  );

  klp32_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b0), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
    .fifo_count(w_fifo_count)
  );

  always #5 clk = ~clk;

  // stimulus knobs
  int          rdy_pct, irdy_pct, rsp_pct, rsp_budget;
  bit          redir, rst;
  logic [31:0] redir_pc;

  // model: in-flight requests (kind 0 live, 1 stale, 2 forgotten by reset) and expected FIFO
  logic [31:0] q_addr[$];
  int          q_kind[$];
  int          q_cyc[$];
  logic [31:0] e_pc[$];
  logic [31:0] e_data[$];
  logic [31:0] nxt_pc;
  bit          boot_m;
  int          cyc, n_pop;
  bit          got_pop, rsp_sent;
  logic [31:0] first_pop_pc;
  logic [31:0] w_addrs[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int          live, k;
    bit          ev_req, ev_inst, fire, pp;
    logic [31:0] a;
    @(negedge clk);
    reset          = rst;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready     = ($urandom_range(99) < irdy_pct);
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    rsp_sent = 1'b0;
    if (!rst && q_addr.size() > 0 && q_cyc[0] < cyc && rsp_budget != 0 &&
        $urandom_range(99) < rsp_pct)
      rsp_sent = 1'b1;
    imem_rsp_valid = rsp_sent;
    imem_rsp_data  = rsp_sent ? mem(q_addr[0]) : $urandom;
    #1;
    live = 0;
    foreach (q_kind[i]) if (q_kind[i] < 2) live++;
    ev_req  = !rst && !boot_m && !redir && (e_pc.size() + live < DEPTH);
    ev_inst = !rst && (e_pc.size() != 0) && !redir;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ev_req});
    if (ev_req) chk("req_addr", imem_req_addr, nxt_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, ev_inst});
    if (ev_inst) begin
      chk("inst_pc", inst_pc, e_pc[0]);
      chk("inst_data", inst_data, e_data[0]);
    end
    chk("fifo_count", {29'b0, fifo_count}, rst ? 32'd0 : 32'(e_pc.size()));
    if (w_req_valid && w_addrs.size() < 3) w_addrs.push_back(w_req_addr);

    fire = ev_req && imem_req_ready;
    pp   = ev_inst && inst_ready;
    if (rst) begin
      e_pc.delete();
      e_data.delete();
      foreach (q_kind[i]) q_kind[i] = 2;
      nxt_pc = 32'h0;
      boot_m = 1'b1;
    end else begin
      if (pp) begin
        if (!got_pop) begin
          got_pop      = 1'b1;
          first_pop_pc = e_pc[0];
        end
        void'(e_pc.pop_front());
        void'(e_data.pop_front());
        n_pop++;
      end
      if (rsp_sent) begin
        a = q_addr.pop_front();
        k = q_kind.pop_front();
        void'(q_cyc.pop_front());
        if (rsp_budget > 0) rsp_budget--;
        if (k == 0 && !redir) begin
          e_pc.push_back(a);
          e_data.push_back(mem(a));
        end
      end
      if (fire) begin
        q_addr.push_back(nxt_pc);
        q_kind.push_back(0);
        q_cyc.push_back(cyc);
        nxt_pc = nxt_pc + 32'd4;
      end
      if (redir) begin
        e_pc.delete();
        e_data.delete();
        foreach (q_kind[i]) if (q_kind[i] == 0) q_kind[i] = 1;
        nxt_pc = {redir_pc[31:2], 2'b00};
      end
      boot_m = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    int p0;
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    rst = 1'b1; rdy_pct = 100; irdy_pct = 100; rsp_pct = 100; rsp_budget = -1;
    redir = 1'b0; redir_pc = '0; nxt_pc = '0; boot_m = 1'b1; cyc = 0; n_pop = 0;
    got_pop = 1'b0; first_pop_pc = '0;

    // reset, then the idle cycle that follows it
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("boot_req_idle", {31'b0, imem_req_valid}, 32'd0);

    // streaming at full rate from address 0
    repeat (9) step();
    p0 = n_pop;
    repeat (30) step();
    chk("stream_rate", 32'(n_pop - p0), 32'd30);
    chk("stream_first_pc", first_pop_pc, 32'h0);

    // wrap of the fetch address past the top of memory
    chk("wrap_cnt", 32'(w_addrs.size()), 32'd3);
    if (w_addrs.size() == 3) begin
      chk("wrap_a0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_a1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_a2", w_addrs[2], 32'h0000_0000);
    end

    // decode stall: buffer saturates, credit stops requests
    irdy_pct = 0;
    repeat (10) step();
    chk("stall_count", {29'b0, fifo_count}, 32'd4);
    chk("stall_req", {31'b0, imem_req_valid}, 32'd0);
    irdy_pct = 100;
    repeat (10) step();

    // redirect with two requests in flight
    rdy_pct = 0;
    repeat (8) step();
    chk("drained", {29'b0, fifo_count}, 32'd0);
    rsp_pct = 0; rdy_pct = 100;
    repeat (2) step();
    rdy_pct = 0; redir = 1'b1; redir_pc = 32'h0000_0102;
    step();
    redir = 1'b0; rdy_pct = 100; rsp_pct = 100; got_pop = 1'b0;
    step();
    chk("redir_next_req", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_next_addr", imem_req_addr, 32'h0000_0100);
    repeat (8) step();
    chk("redir_got_pop", {31'b0, got_pop}, 32'd1);
    chk("redir_first_pc", first_pop_pc, 32'h0000_0100);

    // redirect in the same cycle as a response, decode ready
    repeat (5) step();
    redir = 1'b1; redir_pc = 32'h0000_2000;
    step();
    redir = 1'b0;
    chk("coinc_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("coinc_count", {29'b0, fifo_count}, 32'd0);
    repeat (6) step();

    // back-to-back redirects: last one wins
    redir = 1'b1; redir_pc = 32'h0000_3000;
    step();
    redir_pc = 32'h0000_4006;
    step();
    redir = 1'b0; got_pop = 1'b0;
    repeat (10) step();
    chk("b2b_first_pc", first_pop_pc, 32'h0000_4004);

    // randomized traffic with occasional redirects
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) begin
        rdy_pct  = $urandom_range(30, 100);
        irdy_pct = $urandom_range(20, 100);
        rsp_pct  = $urandom_range(30, 100);
      end
      redir    = ($urandom_range(99) < 4);
      redir_pc = $urandom;
      step();
    end
    redir = 1'b0; rdy_pct = 100; irdy_pct = 100; rsp_pct = 100;
    repeat (10) step();

    // reset with three buffered and one outstanding
    rdy_pct = 0;
    repeat (8) step();
    irdy_pct = 0; rsp_pct = 0; rdy_pct = 100;
    repeat (5) step();
    rdy_pct = 0; rsp_pct = 100; rsp_budget = 3;
    repeat (5) step();
    chk("pre_rst_count", {29'b0, fifo_count}, 32'd3);
    rst = 1'b1; rsp_budget = -1;
    step();
    chk("rst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst", {31'b0, inst_valid}, 32'd0);
    chk("rst_count", {29'b0, fifo_count}, 32'd0);
    rst = 1'b0; rdy_pct = 100; irdy_pct = 100; got_pop = 1'b0;
    step();
    chk("post_rst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("post_rst_count", {29'b0, fifo_count}, 32'd0);
    repeat (10) step();
    chk("post_rst_first_pc", first_pop_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
